beat_sequencer: RTL and testbench

BEAT_SEQUENCER -- requirements
Module: beat_sequencer

---
 rtl/beat_sequencer.sv | 143 ++++++++++++++
 tb/tb_beat_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/beat_sequencer.sv
// Beat sequencer: steps an instruction through one-hot beats W[k], retires it and
// counts it, and inserts an interrupt-acknowledge beat or halts between instructions.
module beat_sequencer #(
  parameter int NBEAT = 4,
  parameter int OPW   = 4
) (
  input  logic             T3,
  input  logic             CLR,
  input  logic             SWC,
  input  logic             SWB,
  input  logic             SWA,
  input  logic [OPW-1:0]   IRH,
  input  logic             SHORT,
  input  logic             LONG,
  input  logic             INTR,
  input  logic             INTEN,
  output logic [NBEAT-1:0] W,
  output logic             ST0,
  output logic [2:0]       BEAT,
  output logic             INTA,
  output logic             STOP,
  output logic [15:0]      ICNT
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_ACK, S_HALT} state_e;

  localparam logic [4:0]     LAST_MAX = 5'(NBEAT - 1);
  localparam logic [OPW-1:0] OP_LD    = OPW'(4'b0101);
  localparam logic [OPW-1:0] OP_ST    = OPW'(4'b0110);
  localparam logic [OPW-1:0] OP_STP   = OPW'(4'b1110);

  state_e            state_q, state_d;
  logic [2:0]        beat_q, beat_d;
  logic [3:0]        ext_q, ext_d;
  logic              pend_q, pend_d;
  logic [15:0]       icnt_q, icnt_d;
  logic [NBEAT-1:0]  w_q, w_d;
  logic              st0_q, st0_d;
  logic              inta_q, inta_d;
  logic              stop_q, stop_d;

  logic       run_mode;
  logic [4:0] base_last, last_raw, last_beat;
  logic       is_last;

  assign run_mode  = ~(SWC | SWB | SWA);
  // ext_q counts LONG beats already taken; the current LONG extends this beat too
  assign base_last = (IRH == OP_LD || IRH == OP_ST) ? 5'd2 : 5'd1;
  assign last_raw  = base_last + {1'b0, ext_q} + {4'b0, LONG};
  assign last_beat = (last_raw > LAST_MAX) ? LAST_MAX : last_raw;
  assign is_last   = (beat_q == 3'd0 && SHORT) || ({2'b0, beat_q} >= last_beat);

  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      ext_q   <= '0;
      pend_q  <= 1'b0;
      icnt_q  <= '0;
      w_q     <= '0;
      st0_q   <= 1'b0;
      inta_q  <= 1'b0;
      stop_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ext_q   <= ext_d;
      pend_q  <= pend_d;
      icnt_q  <= icnt_d;
      w_q     <= w_d;
      st0_q   <= st0_d;
      inta_q  <= inta_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ext_d   = ext_q;
    pend_d  = pend_q | INTR;
    icnt_d  = icnt_q;
    if (!run_mode) begin
      state_d = S_IDLE;
      beat_d  = '0;
      ext_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin state_d = S_INIT; beat_d = '0; ext_d = '0; end
        S_INIT: begin state_d = S_RUN;  beat_d = '0; ext_d = '0; end
        S_RUN: begin
          if (is_last) begin
            icnt_d = icnt_q + 16'd1;
            beat_d = '0;
            ext_d  = '0;
            // halt has priority; the pending interrupt survives into the next run
            if (IRH == OP_STP && beat_q != 3'd0) state_d = S_HALT;
            else if (pend_q && INTEN) begin
              state_d = S_ACK;
              pend_d  = 1'b0;
            end else state_d = S_RUN;
          end else begin
            beat_d = beat_q + 3'd1;
            ext_d  = ext_q + {3'b0, LONG};
          end
        end
        S_ACK:  begin state_d = S_RUN; beat_d = '0; ext_d = '0; end
        S_HALT: state_d = S_HALT;
        default: begin state_d = S_IDLE; beat_d = '0; ext_d = '0; end
      endcase
    end
  end

  always_comb begin
    w_d    = '0;
    st0_d  = 1'b0;
    inta_d = 1'b0;
    stop_d = 1'b1;
    case (state_d)
      S_INIT: w_d[0] = 1'b1;
      S_RUN: begin
        w_d    = NBEAT'(1) << beat_d;
        st0_d  = 1'b1;
        stop_d = 1'b0;
      end
      S_ACK: begin
        st0_d  = 1'b1;
        inta_d = 1'b1;
        stop_d = 1'b0;
      end
      S_HALT: st0_d = 1'b1;
      default: ;
    endcase
  end

  assign W    = w_q;
  assign ST0  = st0_q;
  assign BEAT = beat_q;
  assign INTA = inta_q;
  assign STOP = stop_q;
  assign ICNT = icnt_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer: NBEAT=4 main instance plus an NBEAT=2 instance
// sharing the same stimulus for the length clamp.
module tb_beat_sequencer;

  logic       T3, CLR, SWC, SWB, SWA, SHORT, LONG, INTR, INTEN;
  logic [3:0] IRH;

  logic [3:0]  W;
  logic        ST0, INTA, STOP;
  logic [2:0]  BEAT;
  logic [15:0] ICNT;

  logic [1:0]  W2;
  logic        ST0_2, INTA2, STOP2;
  logic [2:0]  BEAT2;
  logic [15:0] ICNT2;

  int passed = 0;
  int total  = 0;
  logic [25:0] e;
  logic [23:0] e2;

  beat_sequencer #(.NBEAT(4), .OPW(4)) dut (
    .T3(T3), .CLR(CLR), .SWC(SWC), .SWB(SWB), .SWA(SWA), .IRH(IRH),
    .SHORT(SHORT), .LONG(LONG), .INTR(INTR), .INTEN(INTEN),
    .W(W), .ST0(ST0), .BEAT(BEAT), .INTA(INTA), .STOP(STOP), .ICNT(ICNT));

  beat_sequencer #(.NBEAT(2), .OPW(4)) dut2 (
    .T3(T3), .CLR(CLR), .SWC(SWC), .SWB(SWB), .SWA(SWA), .IRH(IRH),
    .SHORT(SHORT), .LONG(LONG), .INTR(INTR), .INTEN(INTEN),
    .W(W2), .ST0(ST0_2), .BEAT(BEAT2), .INTA(INTA2), .STOP(STOP2), .ICNT(ICNT2));

  initial T3 = 1'b1;
  always #5 T3 = ~T3;

  function automatic logic [25:0] obs();
    return {W, BEAT, ST0, INTA, STOP, ICNT};
  endfunction

  function automatic logic [23:0] obs2();
    return {W2, BEAT2, ST0_2, INTA2, STOP2, ICNT2};
  endfunction

  function automatic logic [25:0] ev(input logic [3:0] w, input int b, input logic s,
                                     input logic ia, input logic sp, input int c);
    return {w, 3'(b), s, ia, sp, 16'(c)};
  endfunction

  function automatic logic [23:0] ev2(input logic [1:0] w, input int b, input logic s,
                                      input logic ia, input logic sp, input int c);
    return {w, 3'(b), s, ia, sp, 16'(c)};
  endfunction

  task automatic step();
    @(negedge T3);
    #1;
  endtask

  task automatic test_reset();
    CLR = 1'b1; {SWC, SWB, SWA} = 3'b001; IRH = 4'b0001;
    SHORT = 0; LONG = 0; INTR = 0; INTEN = 0;
    #2 CLR = 1'b0;
    #1;
    e = ev(4'b0000, 0, 0, 0, 1, 0); total++;
    if (obs() !== e) $display("FAIL reset_async: got %h exp %h", obs(), e); else passed++;
    step();
    e = ev(4'b0000, 0, 0, 0, 1, 0); total++;
    if (obs() !== e) $display("FAIL reset_held: got %h exp %h", obs(), e); else passed++;
  endtask

  task automatic test_startup();
    {SWC, SWB, SWA} = 3'b000; IRH = 4'b0001; CLR = 1'b1;
    step(); e = ev(4'b0001, 0, 0, 0, 1, 0); total++;
    if (obs() !== e) $display("FAIL start_init: got %h exp %h", obs(), e); else passed++;
    step(); e = ev(4'b0001, 0, 1, 0, 0, 0); total++;
    if (obs() !== e) $display("FAIL start_b0: got %h exp %h", obs(), e); else passed++;
    step(); e = ev(4'b0010, 1, 1, 0, 0, 0); total++;
    if (obs() !== e) $display("FAIL start_b1: got %h exp %h", obs(), e); else passed++;
    step(); e = ev(4'b0001, 0, 1, 0, 0, 1); total++;
    if (obs() !== e) $display("FAIL start_ret1: got %h exp %h", obs(), e); else passed++;
    step(); e = ev(4'b0010, 1, 1, 0, 0, 1); total++;
    if (obs() !== e) $display("FAIL start_b1b: got %h exp %h", obs(), e); else passed++;
    step(); e = ev(4'b0001, 0, 1, 0, 0, 2); total++;
    if (obs() !== e) $display("FAIL start_ret2: got %h exp %h", obs(), e); else passed++;
  endtask

  task automatic test_long();
    IRH = 4'b0101;
    step(); e = ev(4'b0010, 1, 1, 0, 0, 2); total++;
    if (obs() !== e) $display("FAIL long_b1: got %h exp %h", obs(), e); else passed++;
    LONG = 1'b1;
    step(); e = ev(4'b0100, 2, 1, 0, 0, 2); total++;
    if (obs() !== e) $display("FAIL long_b2: got %h exp %h", obs(), e); else passed++;
    LONG = 1'b0;
    step(); e = ev(4'b1000, 3, 1, 0, 0, 2); total++;
    if (obs() !== e) $display("FAIL long_b3: got %h exp %h", obs(), e); else passed++;
    step(); e = ev(4'b0001, 0, 1, 0, 0, 3); total++;
    if (obs() !== e) $display("FAIL long_ret: got %h exp %h", obs(), e); else passed++;
  endtask

  task automatic test_short();
    IRH = 4'b0001; SHORT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); e = ev(4'b0001, 0, 1, 0, 0, 4 + i); total++;
      if (obs() !== e) $display("FAIL short_%0d: got %h exp %h", i, obs(), e); else passed++;
    end
    SHORT = 1'b0;
  endtask

  task automatic test_interrupt();
    INTEN = 1'b1; INTR = 1'b1;
    step(); e = ev(4'b0010, 1, 1, 0, 0, 6); total++;
    if (obs() !== e) $display("FAIL intr_b1: got %h exp %h", obs(), e); else passed++;
    INTR = 1'b0;
    step(); e = ev(4'b0000, 0, 1, 1, 0, 7); total++;
    if (obs() !== e) $display("FAIL intr_ack: got %h exp %h", obs(), e); else passed++;
    step(); e = ev(4'b0001, 0, 1, 0, 0, 7); total++;
    if (obs() !== e) $display("FAIL intr_resume: got %h exp %h", obs(), e); else passed++;
    step(); e = ev(4'b0010, 1, 1, 0, 0, 7); total++;
    if (obs() !== e) $display("FAIL intr_b1b: got %h exp %h", obs(), e); else passed++;
    step(); e = ev(4'b0001, 0, 1, 0, 0, 8); total++;
    if (obs() !== e) $display("FAIL intr_no_second: got %h exp %h", obs(), e); else passed++;
  endtask

  task automatic test_halt();
    IRH = 4'b1110; INTR = 1'b1;
    step(); e = ev(4'b0010, 1, 1, 0, 0, 8); total++;
    if (obs() !== e) $display("FAIL halt_b1: got %h exp %h", obs(), e); else passed++;
    INTR = 1'b0;
    step(); e = ev(4'b0000, 0, 1, 0, 1, 9); total++;
    if (obs() !== e) $display("FAIL halt_enter: got %h exp %h", obs(), e); else passed++;
    step(); e = ev(4'b0000, 0, 1, 0, 1, 9); total++;
    if (obs() !== e) $display("FAIL halt_stay: got %h exp %h", obs(), e); else passed++;
    {SWC, SWB, SWA} = 3'b001;
    step(); e = ev(4'b0000, 0, 0, 0, 1, 9); total++;
    if (obs() !== e) $display("FAIL halt_idle: got %h exp %h", obs(), e); else passed++;
    {SWC, SWB, SWA} = 3'b000; IRH = 4'b0001;
    step(); e = ev(4'b0001, 0, 0, 0, 1, 9); total++;
    if (obs() !== e) $display("FAIL halt_init: got %h exp %h", obs(), e); else passed++;
    step(); step(); e = ev(4'b0010, 1, 1, 0, 0, 9); total++;
    if (obs() !== e) $display("FAIL halt_run_b1: got %h exp %h", obs(), e); else passed++;
    step(); e = ev(4'b0000, 0, 1, 1, 0, 10); total++;
    if (obs() !== e) $display("FAIL halt_pending_ack: got %h exp %h", obs(), e); else passed++;
    step(); e = ev(4'b0001, 0, 1, 0, 0, 10); total++;
    if (obs() !== e) $display("FAIL halt_after_ack: got %h exp %h", obs(), e); else passed++;
  endtask

  task automatic test_abandon();
    IRH = 4'b0101;
    step(); e = ev(4'b0010, 1, 1, 0, 0, 10); total++;
    if (obs() !== e) $display("FAIL abandon_b1: got %h exp %h", obs(), e); else passed++;
    {SWC, SWB, SWA} = 3'b010;
    step(); e = ev(4'b0000, 0, 0, 0, 1, 10); total++;
    if (obs() !== e) $display("FAIL abandon_idle: got %h exp %h", obs(), e); else passed++;
    {SWC, SWB, SWA} = 3'b000;
    step(); step(); e = ev(4'b0001, 0, 1, 0, 0, 10); total++;
    if (obs() !== e) $display("FAIL abandon_restart: got %h exp %h", obs(), e); else passed++;
  endtask

  task automatic test_async_reset();
    IRH = 4'b0101;
    step(); step(); e = ev(4'b0100, 2, 1, 0, 0, 10); total++;
    if (obs() !== e) $display("FAIL areset_b2: got %h exp %h", obs(), e); else passed++;
    #2 CLR = 1'b0;
    #1; e = ev(4'b0000, 0, 0, 0, 1, 0); total++;
    if (obs() !== e) $display("FAIL areset_clear: got %h exp %h", obs(), e); else passed++;
    step(); CLR = 1'b1; IRH = 4'b0001;
    step(); e = ev(4'b0001, 0, 0, 0, 1, 0); total++;
    if (obs() !== e) $display("FAIL areset_init: got %h exp %h", obs(), e); else passed++;
    step(); e = ev(4'b0001, 0, 1, 0, 0, 0); total++;
    if (obs() !== e) $display("FAIL areset_run: got %h exp %h", obs(), e); else passed++;
    e2 = ev2(2'b01, 0, 1, 0, 0, 0); total++;
    if (obs2() !== e2) $display("FAIL areset_run_n2: got %h exp %h", obs2(), e2); else passed++;
  endtask

  task automatic test_clamp();
    IRH = 4'b0101;
    step(); e2 = ev2(2'b10, 1, 1, 0, 0, 0); total++;
    if (obs2() !== e2) $display("FAIL clamp_n2_b1: got %h exp %h", obs2(), e2); else passed++;
    step(); e2 = ev2(2'b01, 0, 1, 0, 0, 1); total++;
    if (obs2() !== e2) $display("FAIL clamp_n2_ret: got %h exp %h", obs2(), e2); else passed++;
    e = ev(4'b0100, 2, 1, 0, 0, 0); total++;
    if (obs() !== e) $display("FAIL clamp_n4_b2: got %h exp %h", obs(), e); else passed++;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_long();
    test_short();
    test_interrupt();
    test_halt();
    test_abandon();
    test_async_reset();
    test_clamp();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
